// File: rtl/gdp_sched.sv
// Sweep scheduler for the Gaussian distance pipeline. It issues observation and
// parameter reads and streams framed elements into gdp. It also collects per-component scores and the argmax.
module gdp_sched #(
    parameter int N_GAUSS = 8,
    parameter int N_DIM   = 4
) (
    input  logic                                                        clk,
    input  logic                                                        reset,
    input  logic                                                        start,
    output logic                                                        busy,
    output logic                                                        done,
    output logic [((N_DIM > 1) ? $clog2(N_DIM) : 1)-1:0]                x_addr,
    input  logic [15:0]                                                 x_data,
    output logic [((N_GAUSS*N_DIM > 1) ? $clog2(N_GAUSS*N_DIM) : 1)-1:0] p_addr,
    input  logic [15:0]                                                 p_k,
    input  logic [15:0]                                                 p_omega,
    input  logic [15:0]                                                 p_mean,
    output logic                                                        gdp_first,
    output logic                                                        gdp_last,
    output logic [15:0]                                                 gdp_x,
    output logic [15:0]                                                 gdp_k,
    output logic [15:0]                                                 gdp_omega,
    output logic [15:0]                                                 gdp_mean,
    input  logic                                                        gdp_ready,
    input  logic [15:0]                                                 gdp_ln_p,
    output logic                                                        score_valid,
    output logic [((N_GAUSS > 1) ? $clog2(N_GAUSS) : 1)-1:0]            score_idx,
    output logic [15:0]                                                 score,
    output logic [((N_GAUSS > 1) ? $clog2(N_GAUSS) : 1)-1:0]            best_idx,
    output logic [15:0]                                                 best_ln_p
);

    localparam int XW = (N_DIM > 1) ? $clog2(N_DIM) : 1;
    localparam int PW = (N_GAUSS*N_DIM > 1) ? $clog2(N_GAUSS*N_DIM) : 1;
    localparam int GW = (N_GAUSS > 1) ? $clog2(N_GAUSS) : 1;

    localparam logic [XW-1:0] D_LAST = XW'(N_DIM - 1);
    localparam logic [PW-1:0] P_LAST = PW'(N_GAUSS*N_DIM - 1);
    localparam logic [GW-1:0] R_LAST = GW'(N_GAUSS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        state;
    logic          s1_valid;
    logic          s1_first;
    logic          s1_last;
    logic [GW-1:0] r;

    // p_addr runs linearly over g*N_DIM+d while x_addr wraps every N_DIM words;
    // the flags travel one stage with the read and one stage into the gdp registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            x_addr      <= '0;
            p_addr      <= '0;
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            gdp_first   <= 1'b0;
            gdp_last    <= 1'b0;
            gdp_x       <= '0;
            gdp_k       <= '0;
            gdp_omega   <= '0;
            gdp_mean    <= '0;
            score_valid <= 1'b0;
            score_idx   <= '0;
            score       <= '0;
            best_idx    <= '0;
            best_ln_p   <= '0;
            r           <= '0;
        end else begin
            done        <= 1'b0;
            score_valid <= 1'b0;

            s1_valid <= (state == ISSUE);
            s1_first <= (state == ISSUE) && (x_addr == '0);
            s1_last  <= (state == ISSUE) && (x_addr == D_LAST);

            gdp_first <= s1_valid && s1_first;
            gdp_last  <= s1_valid && s1_last;
            gdp_x     <= s1_valid ? x_data  : '0;
            gdp_k     <= s1_valid ? p_k     : '0;
            gdp_omega <= s1_valid ? p_omega : '0;
            gdp_mean  <= s1_valid ? p_mean  : '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        x_addr    <= '0;
                        p_addr    <= '0;
                        r         <= '0;
                        best_idx  <= '0;
                        best_ln_p <= '0;
                    end
                end
                ISSUE: begin
                    if (p_addr == P_LAST) begin
                        state  <= DRAIN;
                        x_addr <= '0;
                        p_addr <= '0;
                    end else begin
                        p_addr <= p_addr + PW'(1);
                        x_addr <= (x_addr == D_LAST) ? '0 : x_addr + XW'(1);
                    end
                end
                DRAIN: begin
                end
                default: state <= IDLE;
            endcase

            // Results come back in issue order, so the running count is the component index.
            if (state != IDLE && gdp_ready) begin
                score_valid <= 1'b1;
                score_idx   <= r;
                score       <= gdp_ln_p;
                if (r == '0 || $signed(gdp_ln_p) > $signed(best_ln_p)) begin
                    best_idx  <= r;
                    best_ln_p <= gdp_ln_p;
                end
                if (r == R_LAST) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    r <= r + GW'(1);
                end
            end
        end
    end

endmodule
